fc_weight_updater: RTL
======================

FC_WEIGHT_UPDATER -- requirements
Module: fc_weight_updater

Interface
REQ-001 Parameter N_IN, default 128, FC layer input count (rows i).
REQ-002 Parameter N_OUT, default 10, FC layer output count (columns j).
REQ-003 Parameter DW, default 16, data width, signed two's complement.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin one update pass.
REQ-007 upd_valid  input  1  update word present on upd_data.
REQ-008 upd_data  input  DW  weight delta for the current (i,j), signed.
REQ-009 upd_ready  output  1  block accepts upd_data this cycle.
REQ-010 mem_addr  output  11  weight memory address, i*N_OUT+j.
REQ-011 mem_rd_en  output  1  weight memory read strobe.
REQ-012 mem_rdata  input  DW  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 mem_wr_en  output  1  weight memory write strobe.
REQ-014 mem_wdata  output  DW  updated weight.
REQ-015 busy  output  1  high from pass start until done.
REQ-016 done  output  1  one-cycle pulse at pass completion.
REQ-017 sat_count  output  11  saturation events in the last/current pass.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, RDWAIT, WRITE, FINISH.
REQ-019 IDLE: start=1 SHALL clear addr and sat_count, then enter FETCH.
REQ-020 FETCH: upd_ready=1 and no other state asserts it; on upd_valid&&upd_ready, capture upd_data, assert mem_rd_en with mem_addr=addr, enter RDWAIT.
REQ-021 FETCH without upd_valid SHALL hold state, addr, and all memory strobes low.
REQ-022 RDWAIT SHALL always advance to WRITE after one cycle.
REQ-023 WRITE SHALL assert mem_wr_en for one cycle with mem_addr=addr and mem_wdata=sat(mem_rdata - captured update).
REQ-024 Subtraction SHALL use DW+1 bits; results above 2^(DW-1)-1 or below -2^(DW-1) SHALL clamp to those limits and increment sat_count (saturating at 2047).
REQ-025 Stream order SHALL be i outer (0..N_IN-1), j inner (0..N_OUT-1); addr SHALL increment linearly by 1 per word.
REQ-026 In WRITE, addr=N_IN*N_OUT-1 SHALL enter FINISH; otherwise addr+1 and enter FETCH.
REQ-027 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-028 busy SHALL be high in FETCH, RDWAIT, WRITE, FINISH.
REQ-029 start while busy SHALL be ignored.
REQ-030 Throughput SHALL be 3 cycles per weight minimum; a full default pass completes in 3*1280+1 cycles after start given continuous upd_valid.
REQ-031 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-032 sat_count SHALL hold its value after done until the next accepted start.

Reset
REQ-033 rst=0 at a clock edge SHALL force IDLE, addr=0, sat_count=0, upd_ready=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
REQ-034 Reset mid-pass SHALL abort without issuing any further memory write; partial writes already issued remain.

Structure
REQ-035 A shared package SHALL hold N_IN, N_OUT, DW, the address width, and the FSM state enumeration used also by the backpropagation stage.
REQ-036 The saturating subtractor SHALL be one combinational sub-module, sat_sub.

Verification
REQ-037 Weight 0x0100, update 0x0040 at addr 0 -> write 0x00C0 at addr 0, sat_count 0.
REQ-038 Weight 0x8010, update 0x0020 -> write 0x8000, sat_count 1; weight 0x7FF0, update 0xFFE0 -> write 0x7FFF, sat_count 2.
REQ-039 Full pass, continuous upd_valid, all updates 1 -> 1280 writes at addr 0..1279 in order, done one cycle at cycle 3841, busy falls with done's return to IDLE.
REQ-040 upd_valid dropped for 5 cycles mid-pass -> no strobes during gap, addr unchanged, pass resumes at same address.
REQ-041 start pulsed again at addr 500 -> ignored; rst low at addr 700 -> IDLE next cycle, no write at 700, busy=0.
REQ-042 Assertions: rd_en/wr_en never coincident; upd_ready only in FETCH; done exactly one cycle per pass.

Source files
------------

// File: rtl/fc_weight_updater_pkg.sv
// fc_weight_updater_pkg: shared FC layer sizes, widths and update FSM states.
package fc_weight_updater_pkg;
  localparam int N_IN = 128;
  localparam int N_OUT = 10;
  localparam int DW = 16;
  localparam int AW = 11;
  localparam int CW = 11;
  typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, WRITE, FINISH} fc_state_e;
endpackage

// File: rtl/fc_weight_updater_sat_sub.sv
// sat_sub: signed a-b computed one bit wider, clamped to the DW-bit range.
module sat_sub #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          sat
);
  logic [DW:0] diff;
  always_comb begin
    diff = {a[DW-1], a} - {b[DW-1], b};
    sat = diff[DW] ^ diff[DW-1];
    y = sat ? {diff[DW], {(DW-1){~diff[DW]}}} : diff[DW-1:0];
  end
endmodule

// File: rtl/fc_weight_updater.sv
// fc_weight_updater: streams deltas over the FC weight memory, writing sat(w - delta) per weight.
module fc_weight_updater #(
  parameter int N_IN = fc_weight_updater_pkg::N_IN,
  parameter int N_OUT = fc_weight_updater_pkg::N_OUT,
  parameter int DW = fc_weight_updater_pkg::DW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              upd_valid,
  input  logic [DW-1:0]                     upd_data,
  output logic                              upd_ready,
  output logic [fc_weight_updater_pkg::AW-1:0] mem_addr,
  output logic                              mem_rd_en,
  input  logic [DW-1:0]                     mem_rdata,
  output logic                              mem_wr_en,
  output logic [DW-1:0]                     mem_wdata,
  output logic                              busy,
  output logic                              done,
  output logic [fc_weight_updater_pkg::CW-1:0] sat_count
);
  import fc_weight_updater_pkg::*;
  localparam logic [AW-1:0] LAST = AW'(N_IN * N_OUT - 1);
  localparam logic [CW-1:0] SAT_MAX = '1;
  fc_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] sat_q, sat_d;
  logic [DW-1:0] upd_q, upd_d, wdata_q, wdata_d, sub_y;
  logic sub_sat;
  sat_sub #(.DW(DW)) u_sat_sub (.a(mem_rdata), .b(upd_q), .y(sub_y), .sat(sub_sat));
  // Read is issued in the accept cycle so read data lands during RDWAIT and the result is registered into WRITE.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    sat_d = sat_q;
    upd_d = upd_q;
    wdata_d = wdata_q;
    mem_rd_en = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        addr_d = '0;
        sat_d = '0;
        state_d = FETCH;
      end
      FETCH: if (upd_valid) begin
        upd_d = upd_data;
        mem_rd_en = 1'b1;
        state_d = RDWAIT;
      end
      RDWAIT: begin
        wdata_d = sub_y;
        sat_d = sat_q + CW'(sub_sat && sat_q != SAT_MAX);
        state_d = WRITE;
      end
      WRITE: begin
        addr_d = addr_q == LAST ? addr_q : addr_q + 1'b1;
        state_d = addr_q == LAST ? FINISH : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      sat_q <= '0;
      upd_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      sat_q <= sat_d;
      upd_q <= upd_d;
      wdata_q <= wdata_d;
    end
  end
  assign upd_ready = state_q == FETCH;
  assign mem_wr_en = state_q == WRITE;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign sat_count = sat_q;
endmodule
